branch_resolve_unit: RTL and testbench

Execute-side counterpart of the fetch-stage BTB lookup.
- Fetch pushes each BTB prediction record into an in-order tracking FIFO.
- When EX resolves a branch, the block pops the oldest record and compares prediction against outcome.
- It then issues the BTB write (pc, destination), plus a flush/redirect on mispredict, and keeps branch/mispredict statistics.

---
 rtl/branch_resolve_unit.sv | 154 +++++++++++++++
 tb/tb_branch_resolve_unit.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
// Execute-side branch resolution: tracks in-flight BTB predictions in order,
// checks them against EX outcomes, and drives BTB updates, redirects and stats.
//
// state   | meaning
// S_RUN   | normal operation, pushes and resolves accepted
// S_FLUSH | one-cycle flush/redirect after a mispredict, FIFO already empty
module branch_resolve_unit #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         pred_valid,
    input  logic [XLEN-1:0]              pred_pc,
    input  logic [XLEN-1:0]              pred_target,
    output logic                         pred_ready,
    input  logic                         res_valid,
    input  logic [XLEN-1:0]              res_pc,
    input  logic                         res_taken,
    input  logic [XLEN-1:0]              res_target,
    output logic                         btb_write_en,
    output logic [XLEN-1:0]              btb_pc,
    output logic [XLEN-1:0]              btb_dest,
    output logic                         redirect_valid,
    output logic [XLEN-1:0]              redirect_pc,
    output logic                         flush,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic [CNT_W-1:0]             branch_count,
    output logic [CNT_W-1:0]             mispredict_count,
    output logic                         order_error
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef enum logic {S_RUN, S_FLUSH} state_t;

    state_t          state_q, state_d;
    logic [XLEN-1:0] pc_mem  [DEPTH];
    logic [XLEN-1:0] tgt_mem [DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            oe_q, oe_d;
    logic            we_q, we_d;
    logic [XLEN-1:0] bpc_q, bpc_d, bdst_q, bdst_d, rpc_q, rpc_d;
    logic [CNT_W-1:0] brc_q, brc_d, misc_q, misc_d;

    logic [XLEN-1:0] head_pc, head_tgt;
    logic            head_ptaken, push, push_eff, res_hit, tgt_wrong, mispredict;

    assign head_pc     = pc_mem[rd_ptr_q];
    assign head_tgt    = tgt_mem[rd_ptr_q];
    assign head_ptaken = (head_tgt != '0);

    assign pred_ready = (count_q < DEPTH_C) && (state_q == S_RUN);
    assign push       = pred_valid && pred_ready;
    assign res_hit    = res_valid && (state_q == S_RUN) && (count_q != '0) && (head_pc == res_pc);
    assign tgt_wrong  = res_taken && (head_tgt != res_target);
    assign mispredict = res_hit && ((head_ptaken != res_taken) || tgt_wrong);
    // A push racing a mispredict belongs to the squashed wrong path.
    assign push_eff   = push && !mispredict;

    always_comb begin
        state_d  = S_RUN;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + CW'(push_eff) - CW'(res_hit);
        oe_d     = oe_q;
        we_d     = 1'b0;
        bpc_d    = bpc_q;
        bdst_d   = bdst_q;
        rpc_d    = rpc_q;
        brc_d    = brc_q;
        misc_d   = misc_q;

        if (res_valid && (state_q == S_RUN) && !res_hit) begin
            oe_d = 1'b1;
        end
        if (push_eff) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (res_hit) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            if (brc_q != '1) brc_d = brc_q + CNT_W'(1);
            if (tgt_wrong) begin
                we_d   = 1'b1;
                bpc_d  = res_pc;
                bdst_d = res_target;
            end else if (!res_taken && head_ptaken) begin
                we_d   = 1'b1;
                bpc_d  = res_pc;
                bdst_d = '0;
            end
        end
        if (mispredict) begin
            state_d  = S_FLUSH;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            rpc_d    = res_taken ? res_target : res_pc + XLEN'(4);
            if (misc_q != '1) misc_d = misc_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_RUN;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            oe_q     <= 1'b0;
            we_q     <= 1'b0;
            bpc_q    <= '0;
            bdst_q   <= '0;
            rpc_q    <= '0;
            brc_q    <= '0;
            misc_q   <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            oe_q     <= oe_d;
            we_q     <= we_d;
            bpc_q    <= bpc_d;
            bdst_q   <= bdst_d;
            rpc_q    <= rpc_d;
            brc_q    <= brc_d;
            misc_q   <= misc_d;
        end
    end

    // Record storage needs no reset: occupancy is tracked by count_q.
    always_ff @(posedge clk) begin
        if (push_eff) begin
            pc_mem[wr_ptr_q]  <= pred_pc;
            tgt_mem[wr_ptr_q] <= pred_target;
        end
    end

    assign flush            = (state_q == S_FLUSH);
    assign redirect_valid   = (state_q == S_FLUSH);
    assign redirect_pc      = rpc_q;
    assign btb_write_en     = we_q;
    assign btb_pc           = bpc_q;
    assign btb_dest         = bdst_q;
    assign fifo_count       = count_q;
    assign branch_count     = brc_q;
    assign mispredict_count = misc_q;
    assign order_error      = oe_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed scenarios plus random traffic
// against a queue-based model; a CNT_W=2 copy shares the stimulus.
module tb_branch_resolve_unit;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] tgt;
    } rec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        pred_valid = 1'b0, res_valid = 1'b0, res_taken = 1'b0;
    logic [31:0] pred_pc = '0, pred_target = '0, res_pc = '0, res_target = '0;

    logic        pred_ready, btb_write_en, redirect_valid, flush, order_error;
    logic [31:0] btb_pc, btb_dest, redirect_pc;
    logic [2:0]  fifo_count;
    logic [15:0] branch_count, mispredict_count;

    logic        pred_ready2, btb_write_en2, redirect_valid2, flush2, order_error2;
    logic [31:0] btb_pc2, btb_dest2, redirect_pc2;
    logic [2:0]  fifo_count2;
    logic [1:0]  branch_count2, mispredict_count2;

    int n_checks = 0;
    int n_errors = 0;

    // model state
    rec_t        m_q[$];
    bit          m_flush, m_oe, m_we;
    int          m_br, m_mis;
    logic [31:0] m_bpc, m_bdst, m_rpc;

    always #5 clk = ~clk;

    branch_resolve_unit #(.DEPTH(4), .XLEN(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst),
        .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_target(pred_target), .pred_ready(pred_ready),
        .res_valid(res_valid), .res_pc(res_pc), .res_taken(res_taken), .res_target(res_target),
        .btb_write_en(btb_write_en), .btb_pc(btb_pc), .btb_dest(btb_dest),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .flush(flush),
        .fifo_count(fifo_count), .branch_count(branch_count),
        .mispredict_count(mispredict_count), .order_error(order_error)
    );

    branch_resolve_unit #(.DEPTH(4), .XLEN(32), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst),
        .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_target(pred_target), .pred_ready(pred_ready2),
        .res_valid(res_valid), .res_pc(res_pc), .res_taken(res_taken), .res_target(res_target),
        .btb_write_en(btb_write_en2), .btb_pc(btb_pc2), .btb_dest(btb_dest2),
        .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2), .flush(flush2),
        .fifo_count(fifo_count2), .branch_count(branch_count2),
        .mispredict_count(mispredict_count2), .order_error(order_error2)
    );

    function automatic logic [1:0] sat2(input int v);
        return (v > 3) ? 2'd3 : 2'(v);
    endfunction

    function automatic bit exp_ready();
        return !m_flush && (m_q.size() < 4);
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_flush = 0; m_oe = 0; m_we = 0;
        m_br = 0; m_mis = 0;
        m_bpc = '0; m_bdst = '0; m_rpc = '0;
    endtask

    task automatic reset_dut();
        pred_valid = 0; res_valid = 0;
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    // Drive one cycle of stimulus, advance the model, return at posedge+1.
    task automatic step(input bit pv, input logic [31:0] ppc, input logic [31:0] ptgt,
                        input bit rv, input logic [31:0] rpc, input bit rt, input logic [31:0] rtgt);
        rec_t h;
        bit   push, ptk, mis;
        pred_valid = pv; pred_pc = ppc; pred_target = ptgt;
        res_valid = rv; res_pc = rpc; res_taken = rt; res_target = rtgt;
        push = pv && exp_ready();
        mis  = 0;
        m_we = 0;
        if (rv && !m_flush) begin
            if (m_q.size() == 0 || m_q[0].pc != rpc) begin
                m_oe = 1;
            end else begin
                h   = m_q.pop_front();
                m_br++;
                ptk = (h.tgt != 0);
                mis = (ptk != rt) || (rt && h.tgt != rtgt);
                if (rt && h.tgt != rtgt) begin
                    m_we = 1; m_bpc = rpc; m_bdst = rtgt;
                end else if (!rt && ptk) begin
                    m_we = 1; m_bpc = rpc; m_bdst = 0;
                end
                if (mis) begin
                    m_mis++;
                    m_rpc = rt ? rtgt : rpc + 32'd4;
                end
            end
        end
        m_flush = mis;
        if (mis) m_q.delete();
        else if (push) m_q.push_back({ppc, ptgt});
        @(posedge clk); #1;
        pred_valid = 0; res_valid = 0;
    endtask

    task automatic idle();
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        #1;
        n_checks++;
        if ({btb_write_en, flush, redirect_valid, order_error, fifo_count} !== 7'b0) begin
            n_errors++; $display("FAIL reset_strobes got %b exp 0", {btb_write_en, flush, redirect_valid, order_error, fifo_count});
        end
        n_checks++;
        if ({btb_pc, btb_dest, redirect_pc, branch_count, mispredict_count} !== '0) begin
            n_errors++; $display("FAIL reset_values got %h/%h/%h/%0d/%0d exp all 0", btb_pc, btb_dest, redirect_pc, branch_count, mispredict_count);
        end
        reset_dut();
        n_checks++;
        if (pred_ready !== 1'b1) begin
            n_errors++; $display("FAIL reset_ready got %b exp 1", pred_ready);
        end
    endtask

    task automatic test_correct_taken();
        reset_dut();
        step(1, 32'h100, 32'h200, 0, 0, 0, 0);
        n_checks++;
        if (fifo_count !== 3'd1) begin
            n_errors++; $display("FAIL ct_push_count got %0d exp 1", fifo_count);
        end
        step(0, 0, 0, 1, 32'h100, 1, 32'h200);
        n_checks++;
        if ({btb_write_en, flush, redirect_valid, fifo_count, branch_count, mispredict_count} !== {3'b000, 3'd0, 16'd1, 16'd0}) begin
            n_errors++; $display("FAIL ct_resolve got we%b fl%b rv%b cnt%0d br%0d mis%0d exp 0 0 0 0 1 0",
                                 btb_write_en, flush, redirect_valid, fifo_count, branch_count, mispredict_count);
        end
    endtask

    task automatic test_cold_miss();
        reset_dut();
        step(1, 32'h40, 32'h0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'h40, 1, 32'h80);
        n_checks++;
        if ({btb_write_en, btb_pc, btb_dest} !== {1'b1, 32'h40, 32'h80}) begin
            n_errors++; $display("FAIL cm_btb got we%b pc%h dest%h exp 1 40 80", btb_write_en, btb_pc, btb_dest);
        end
        n_checks++;
        if ({flush, redirect_valid, redirect_pc, mispredict_count, pred_ready} !== {2'b11, 32'h80, 16'd1, 1'b0}) begin
            n_errors++; $display("FAIL cm_redirect got fl%b rv%b rpc%h mis%0d rdy%b exp 1 1 80 1 0",
                                 flush, redirect_valid, redirect_pc, mispredict_count, pred_ready);
        end
        // push and resolve offered during FLUSH must both be ignored
        step(1, 32'h50, 32'h60, 1, 32'h40, 1, 32'h80);
        n_checks++;
        if ({flush, btb_write_en, pred_ready, order_error, fifo_count, branch_count, btb_pc} !== {3'b001, 1'b0, 3'd0, 16'd1, 32'h40}) begin
            n_errors++; $display("FAIL cm_after_flush got fl%b we%b rdy%b oe%b cnt%0d br%0d bpc%h exp 0 0 1 0 0 1 40",
                                 flush, btb_write_en, pred_ready, order_error, fifo_count, branch_count, btb_pc);
        end
    endtask

    task automatic test_false_taken();
        reset_dut();
        step(1, 32'h10, 32'h30, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'h10, 0, 32'h0);
        n_checks++;
        if ({btb_write_en, btb_pc, btb_dest, flush, redirect_pc} !== {1'b1, 32'h10, 32'h0, 1'b1, 32'h14}) begin
            n_errors++; $display("FAIL ft got we%b pc%h dest%h fl%b rpc%h exp 1 10 0 1 14",
                                 btb_write_en, btb_pc, btb_dest, flush, redirect_pc);
        end
        idle();
    endtask

    task automatic test_squash();
        reset_dut();
        for (int i = 0; i < 3; i++) step(1, 32'h1000 + 32'(i * 4), 32'h0, 0, 0, 0, 0);
        n_checks++;
        if (fifo_count !== 3'd3) begin
            n_errors++; $display("FAIL sq_fill got %0d exp 3", fifo_count);
        end
        step(1, 32'h100C, 32'h0, 1, 32'h1000, 1, 32'h2000);
        n_checks++;
        if ({fifo_count, flush} !== {3'd0, 1'b1}) begin
            n_errors++; $display("FAIL sq_clear got cnt%0d fl%b exp 0 1", fifo_count, flush);
        end
        idle();
        step(0, 0, 0, 1, 32'h1004, 0, 32'h0);
        n_checks++;
        if ({order_error, branch_count, fifo_count, btb_write_en} !== {1'b1, 16'd1, 3'd0, 1'b0}) begin
            n_errors++; $display("FAIL sq_order got oe%b br%0d cnt%0d we%b exp 1 1 0 0", order_error, branch_count, fifo_count, btb_write_en);
        end
    endtask

    task automatic test_full_wrap();
        rec_t h;
        reset_dut();
        for (int i = 0; i < 4; i++) step(1, 32'h200 + 32'(i * 4), 32'h300 + 32'(i * 4), 0, 0, 0, 0);
        n_checks++;
        if ({fifo_count, pred_ready} !== {3'd4, 1'b0}) begin
            n_errors++; $display("FAIL fw_full got cnt%0d rdy%b exp 4 0", fifo_count, pred_ready);
        end
        for (int i = 0; i < 10; i++) begin
            h = m_q[0];
            step(1, 32'h400 + 32'(i * 4), 32'h500 + 32'(i * 4), 1, h.pc, 1, h.tgt);
            n_checks++;
            if ({fifo_count, btb_write_en, flush} !== {3'(m_q.size()), 2'b00}) begin
                n_errors++; $display("FAIL fw_iter%0d got cnt%0d we%b fl%b exp %0d 0 0", i, fifo_count, btb_write_en, flush, m_q.size());
            end
        end
        n_checks++;
        if ({branch_count, mispredict_count, order_error} !== {16'd10, 16'd0, 1'b0}) begin
            n_errors++; $display("FAIL fw_stats got br%0d mis%0d oe%b exp 10 0 0", branch_count, mispredict_count, order_error);
        end
    endtask

    task automatic test_errors_saturation();
        reset_dut();
        step(0, 0, 0, 1, 32'h44, 1, 32'h88);
        n_checks++;
        if ({order_error, branch_count, mispredict_count, btb_write_en, flush} !== {1'b1, 16'd0, 16'd0, 2'b00}) begin
            n_errors++; $display("FAIL err_empty got oe%b br%0d mis%0d we%b fl%b exp 1 0 0 0 0",
                                 order_error, branch_count, mispredict_count, btb_write_en, flush);
        end
        reset_dut();
        for (int i = 0; i < 5; i++) begin
            step(1, 32'h600 + 32'(i * 8), 32'h0, 0, 0, 0, 0);
            step(0, 0, 0, 1, 32'h600 + 32'(i * 8), 1, 32'h900);
            idle();
        end
        n_checks++;
        if ({mispredict_count, mispredict_count2, branch_count2} !== {16'd5, 2'd3, 2'd3}) begin
            n_errors++; $display("FAIL sat got mis%0d mis2=%0d br2=%0d exp 5 3 3", mispredict_count, mispredict_count2, branch_count2);
        end
    endtask

    task automatic test_reset_mid();
        reset_dut();
        step(1, 32'h700, 32'h0, 0, 0, 0, 0);
        step(1, 32'h704, 32'h0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'h700, 1, 32'h7F0);
        rst = 1'b0;
        #1;
        n_checks++;
        if ({flush, redirect_valid, btb_write_en, fifo_count, mispredict_count, branch_count, redirect_pc} !== '0) begin
            n_errors++; $display("FAIL mid_reset got fl%b rv%b we%b cnt%0d mis%0d br%0d rpc%h exp all 0",
                                 flush, redirect_valid, btb_write_en, fifo_count, mispredict_count, branch_count, redirect_pc);
        end
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic [31:0] tpool [3];
        bit          pv, rv, rt;
        logic [31:0] ppc, ptgt, rpc, rtgt;
        tpool[0] = 32'h0; tpool[1] = 32'h2000; tpool[2] = 32'h3000;
        reset_dut();
        for (int c = 0; c < 400; c++) begin
            pv   = ($urandom_range(0, 3) != 0);
            ppc  = 32'h1000 + 32'($urandom_range(0, 7) * 4);
            ptgt = tpool[$urandom_range(0, 2)];
            rv   = ($urandom_range(0, 2) == 0);
            rt   = 1'($urandom_range(0, 1));
            rpc  = (m_q.size() > 0 && $urandom_range(0, 15) != 0) ? m_q[0].pc : 32'h1000 + 32'($urandom_range(0, 7) * 4);
            rtgt = (m_q.size() > 0 && $urandom_range(0, 1) == 1) ? m_q[0].tgt : tpool[$urandom_range(1, 2)];
            step(pv, ppc, ptgt, rv, rpc, rt, rtgt);
            n_checks++;
            if ({fifo_count, pred_ready, btb_write_en, flush, redirect_valid, order_error} !==
                {3'(m_q.size()), exp_ready(), m_we, m_flush, m_flush, m_oe}) begin
                n_errors++; $display("FAIL rnd_ctrl c%0d got cnt%0d rdy%b we%b fl%b rv%b oe%b exp %0d %b %b %b %b %b",
                                     c, fifo_count, pred_ready, btb_write_en, flush, redirect_valid, order_error,
                                     m_q.size(), exp_ready(), m_we, m_flush, m_flush, m_oe);
            end
            n_checks++;
            if ({btb_pc, btb_dest, redirect_pc, branch_count, mispredict_count} !==
                {m_bpc, m_bdst, m_rpc, 16'(m_br), 16'(m_mis)}) begin
                n_errors++; $display("FAIL rnd_data c%0d got bpc%h bd%h rpc%h br%0d mis%0d exp %h %h %h %0d %0d",
                                     c, btb_pc, btb_dest, redirect_pc, branch_count, mispredict_count,
                                     m_bpc, m_bdst, m_rpc, m_br, m_mis);
            end
            n_checks++;
            if ({fifo_count2, pred_ready2, btb_write_en2, flush2, redirect_valid2, order_error2,
                 btb_pc2, btb_dest2, redirect_pc2, branch_count2, mispredict_count2} !==
                {3'(m_q.size()), exp_ready(), m_we, m_flush, m_flush, m_oe,
                 m_bpc, m_bdst, m_rpc, sat2(m_br), sat2(m_mis)}) begin
                n_errors++; $display("FAIL rnd_sat c%0d got br2=%0d mis2=%0d cnt2=%0d exp %0d %0d %0d",
                                     c, branch_count2, mispredict_count2, fifo_count2, sat2(m_br), sat2(m_mis), m_q.size());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_correct_taken();
        test_cold_miss();
        test_false_taken();
        test_squash();
        test_full_wrap();
        test_errors_saturation();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
